// File: rtl/scrambler_ctrl.sv
// scrambler_ctrl: sequences the TX 32-bit scrambler LFSR for 4-symbol-wide lanes.
// Classifies each accepted word as data or ordered set, drives the LFSR reset
// and advance strobes, XORs the keystream onto data bytes and forwards the
// result through one registered valid/ready stage.
//
// Optional build macro SCR_CTRL_STATS_EN: adds the com_cnt[15:0] output, a
// saturating count of accepted byte-0 COM words.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_DATA | words are data (scrambled) unless byte 0 carries a COM
// ST_OS   | inside a multi-word TS1/TS2; words pass unscrambled, os_cnt
//         | words remain after the current one
module scrambler_ctrl #(
    parameter int          TS_WORDS = 4,
    parameter logic [7:0]  COM_SYM  = 8'hBC,
    parameter logic [7:0]  SKP_SYM  = 8'h1C,
    parameter logic [7:0]  FTS_SYM  = 8'h3C,
    parameter logic [7:0]  IDL_SYM  = 8'h7C
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        scr_disable,
    input  logic [31:0] lfsr_data,
    output logic        lfsr_rst,
    output logic        lfsr_adv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_datak,
    output logic        err_misalign
`ifdef SCR_CTRL_STATS_EN
    ,
    output logic [15:0] com_cnt
`endif
);

    localparam logic [0:0] ST_DATA = 1'b0;
    localparam logic [0:0] ST_OS   = 1'b1;
    localparam logic [7:0] OS_LOAD = 8'(TS_WORDS - 2);

    logic [0:0]  state, state_nxt;
    logic [7:0]  os_cnt, os_cnt_nxt;
    logic        acc;
    logic        com0;
    logic        one_word_os;
    logic        misalign;
    logic        scr_word;
    logic [31:0] scr_data;

    assign in_ready = !out_valid | out_ready;
    // Reset gates the strobes so the LFSR is never touched while reset is held.
    assign acc      = in_valid & in_ready & reset_n;

    assign com0 = in_datak[0] & (in_data[7:0] == COM_SYM);

    assign one_word_os = in_datak[1] &
                         ((in_data[15:8] == SKP_SYM) ||
                          (in_data[15:8] == FTS_SYM) ||
                          (in_data[15:8] == IDL_SYM));

    assign misalign = (in_datak[1] & (in_data[15:8]  == COM_SYM)) |
                      (in_datak[2] & (in_data[23:16] == COM_SYM)) |
                      (in_datak[3] & (in_data[31:24] == COM_SYM));

    // Word classification, LFSR strobes and next-state selection.
    // A byte-0 COM always wins, also inside an OS, so a truncated OS restarts.
    always_comb begin
        lfsr_rst   = 1'b0;
        lfsr_adv   = 1'b0;
        scr_word   = 1'b0;
        state_nxt  = state;
        os_cnt_nxt = os_cnt;
        if (acc) begin
            if (com0) begin
                lfsr_rst = 1'b1;
                if (one_word_os) begin
                    state_nxt = ST_DATA;
                end else begin
                    state_nxt  = ST_OS;
                    os_cnt_nxt = OS_LOAD;
                end
            end else if (state == ST_OS) begin
                lfsr_adv = 1'b1;
                if (os_cnt == 8'd0) begin
                    state_nxt = ST_DATA;
                end else begin
                    os_cnt_nxt = os_cnt - 8'd1;
                end
            end else begin
                lfsr_adv = 1'b1;
                scr_word = 1'b1;
            end
        end
    end

    // Byte-wise keystream application; K bytes still consume their keystream byte.
    always_comb begin
        scr_data = in_data;
        for (int i = 0; i < 4; i++) begin
            if (scr_word && !in_datak[i] && !scr_disable) begin
                scr_data[8*i +: 8] = in_data[8*i +: 8] ^ lfsr_data[8*i +: 8];
            end
        end
    end

    // Classification state; only moves on an accepted word.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_DATA;
            os_cnt <= 8'd0;
        end else if (acc) begin
            state  <= state_nxt;
            os_cnt <= os_cnt_nxt;
        end
    end

    // Output register stage; holds while stalled.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_data     <= 32'd0;
            out_datak    <= 4'd0;
            err_misalign <= 1'b0;
        end else begin
            if (in_ready) begin
                out_valid <= in_valid;
            end
            if (acc) begin
                out_data     <= scr_data;
                out_datak    <= in_datak;
                err_misalign <= misalign;
            end
        end
    end

`ifdef SCR_CTRL_STATS_EN
    // Saturating count of accepted byte-0 COM words.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            com_cnt <= 16'd0;
        end else if (acc && com0 && (com_cnt != 16'hFFFF)) begin
            com_cnt <= com_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scrambler_ctrl.sv
// Directed bench for scrambler_ctrl with hand-computed expected values.
module tb_scrambler_ctrl;

    logic        pclk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic        scr_disable;
    logic [31:0] lfsr_data;
    logic        lfsr_rst;
    logic        lfsr_adv;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_datak;
    logic        err_misalign;
`ifdef SCR_CTRL_STATS_EN
    logic [15:0] com_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    scrambler_ctrl dut (
        .pclk         (pclk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_datak     (in_datak),
        .scr_disable  (scr_disable),
        .lfsr_data    (lfsr_data),
        .lfsr_rst     (lfsr_rst),
        .lfsr_adv     (lfsr_adv),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_datak    (out_datak),
        .err_misalign (err_misalign)
`ifdef SCR_CTRL_STATS_EN
        ,
        .com_cnt      (com_cnt)
`endif
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word, check the combinational strobes, then the registered output.
    task automatic xfer(input string tag, input logic [31:0] d, input logic [3:0] k,
                        input logic [31:0] l, input logic dis,
                        input logic e_rst, input logic e_adv,
                        input logic [31:0] e_out, input logic e_err);
        in_valid    = 1'b1;
        in_data     = d;
        in_datak    = k;
        lfsr_data   = l;
        scr_disable = dis;
        #1;
        chk({tag, ".rst"}, 32'(lfsr_rst), 32'(e_rst));
        chk({tag, ".adv"}, 32'(lfsr_adv), 32'(e_adv));
        @(posedge pclk); #1;
        chk({tag, ".ov"},   32'(out_valid), 32'd1);
        chk({tag, ".data"}, out_data, e_out);
        chk({tag, ".k"},    32'(out_datak), 32'(k));
        chk({tag, ".err"},  32'(err_misalign), 32'(e_err));
    endtask

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b1;
        in_data     = 32'h0;
        in_datak    = 4'h0;
        scr_disable = 1'b0;
        lfsr_data   = 32'hFFFF_FFFF;
        out_ready   = 1'b1;

        // reset state, strobes quiet even with in_valid high
        @(posedge pclk); #1;
        chk("rst.ov",   32'(out_valid), 32'd0);
        chk("rst.data", out_data, 32'd0);
        chk("rst.k",    32'(out_datak), 32'd0);
        chk("rst.err",  32'(err_misalign), 32'd0);
        chk("rst.lrst", 32'(lfsr_rst), 32'd0);
        chk("rst.ladv", 32'(lfsr_adv), 32'd0);
        in_valid = 1'b0;
        @(posedge pclk); #1;
        reset_n = 1'b1;

        // plain data word
        xfer("t2", 32'h0000_0000, 4'h0, 32'hA5C3_0FF1, 1'b0, 1'b0, 1'b1, 32'hA5C3_0FF1, 1'b0);

        // TS1: COM word then three unscrambled words, fifth scrambled
        xfer("t3.w0", 32'h10F7_F7BC, 4'b0111, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h10F7_F7BC, 1'b0);
        xfer("t3.w1", 32'h4A4A_4A4A, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h4A4A_4A4A, 1'b0);
        xfer("t3.w2", 32'h4A4A_4A4A, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h4A4A_4A4A, 1'b0);
        xfer("t3.w3", 32'h4A4A_4A4A, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h4A4A_4A4A, 1'b0);
        xfer("t3.w4", 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // SKP: reset only, next word scrambled
        xfer("t4.skp", 32'h1C1C_1CBC, 4'hF, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 32'h1C1C_1CBC, 1'b0);
        xfer("t4.dat", 32'hFFFF_FFFF, 4'h0, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 1'b0);

        // FTS: one-word OS
        xfer("fts.os",  32'h3C3C_3CBC, 4'hF, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 32'h3C3C_3CBC, 1'b0);
        xfer("fts.dat", 32'h0000_0000, 4'h0, 32'h0102_0304, 1'b0, 1'b0, 1'b1, 32'h0102_0304, 1'b0);

        // K byte inside a data word passes unchanged
        xfer("kbyte", 32'h0000_F700, 4'b0010, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b1, 32'hAAAA_F7AA, 1'b0);

        // COM inside a TS aborts it; the SKP that follows leaves us in DATA
        xfer("ab.ts",  32'h10F7_F7BC, 4'b0111, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h10F7_F7BC, 1'b0);
        xfer("ab.w1",  32'h4A4A_4A4A, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h4A4A_4A4A, 1'b0);
        xfer("ab.skp", 32'h1C1C_1CBC, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h1C1C_1CBC, 1'b0);
        xfer("ab.dat", 32'h0000_0000, 4'h0, 32'h7777_7777, 1'b0, 1'b0, 1'b1, 32'h7777_7777, 1'b0);

        // misaligned COM in byte 2
        xfer("mis",    32'h11BC_2233, 4'b0100, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'hEEBC_DDCC, 1'b1);
        xfer("mis.nx", 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0);

        // scrambling disabled
        xfer("dis", 32'h1234_5678, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0);

        // backpressure: previous word (12345678) must hold for 3 stalled cycles
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_data     = 32'h0000_0000;
        in_datak    = 4'h0;
        lfsr_data   = 32'h3333_3333;
        scr_disable = 1'b0;
        #1;
        chk("bp.rdy0", 32'(in_ready), 32'd0);
        chk("bp.adv0", 32'(lfsr_adv), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge pclk); #1;
            chk("bp.ov",   32'(out_valid), 32'd1);
            chk("bp.hold", out_data, 32'h1234_5678);
            chk("bp.rdy",  32'(in_ready), 32'd0);
            chk("bp.adv",  32'(lfsr_adv), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rel.rdy", 32'(in_ready), 32'd1);
        chk("bp.rel.adv", 32'(lfsr_adv), 32'd1);
        @(posedge pclk); #1;
        chk("bp.new.ov",   32'(out_valid), 32'd1);
        chk("bp.new.data", out_data, 32'h3333_3333);
        in_valid = 1'b0;
        #1;
        chk("bp.idle.adv", 32'(lfsr_adv), 32'd0);
        @(posedge pclk); #1;
        chk("bp.nodup", 32'(out_valid), 32'd0);

        // mid-stream reset while inside a TS, output valid
        xfer("t1.ts", 32'h10F7_F7BC, 4'b0111, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h10F7_F7BC, 1'b0);
        xfer("t1.w1", 32'h4A4A_4A4A, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h4A4A_4A4A, 1'b0);
        in_valid  = 1'b1;
        in_data   = 32'h0000_0000;
        in_datak  = 4'h0;
        lfsr_data = 32'h5A5A_5A5A;
        #1;
        reset_n = 1'b0;
        #1;
        chk("t1.ov",   32'(out_valid), 32'd0);
        chk("t1.data", out_data, 32'd0);
        chk("t1.k",    32'(out_datak), 32'd0);
        chk("t1.lrst", 32'(lfsr_rst), 32'd0);
        chk("t1.ladv", 32'(lfsr_adv), 32'd0);
        @(posedge pclk); #1;
        reset_n = 1'b1;
        xfer("t1.first", 32'h0000_0000, 4'h0, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b1, 32'h5A5A_5A5A, 1'b0);
        in_valid = 1'b0;

`ifdef SCR_CTRL_STATS_EN
        // counter cleared by reset, counts byte-0 COM words, saturates
        reset_n = 1'b0;
        @(posedge pclk); #1;
        reset_n = 1'b1;
        chk("st.clr", 32'(com_cnt), 32'd0);
        in_valid  = 1'b1;
        in_data   = 32'h1C1C_1CBC;
        in_datak  = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(posedge pclk); #1;
        end
        chk("st.three", 32'(com_cnt), 32'd3);
        for (int c = 3; c < 65537; c++) begin
            @(posedge pclk); #1;
        end
        in_valid = 1'b0;
        chk("st.sat", 32'(com_cnt), 32'h0000_FFFF);
`endif

        @(posedge pclk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
